fetch_unit: RTL and testbench

- Instruction fetch front end that produces the 32-bit instruction word and its PC for the decode-stage control decoder.
- Issues in-order requests to instruction memory over a valid/ready handshake and buffers returned words in a small FIFO.
- Presents one instruction per cycle to decode.
- Takes redirects from execute (pc_jump OR branch-taken), flushing all buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order imem requests, a small {pc, word} buffer
// feeding decode, and redirect flushing with stale-response drop counting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master imem,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  output logic         inst_valid,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] CAP = (CNT_W+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      pc_mem_q   [BUF_DEPTH];
  logic [31:0]      word_mem_q [BUF_DEPTH];

  logic             accept;
  logic             rsp_hit;
  logic             push;
  logic             pop;
  logic [31:0]      rsp_pc;
  logic [CNT_W:0]   in_use;

  // A pop frees its slot only once count_q has been updated, so the cap uses registered values.
  assign in_use              = {1'b0, outst_q} + {1'b0, count_q};
  assign imem.imem_req_valid = (state_q == FETCH) && !redirect && (in_use < CAP);
  assign imem.imem_req_addr  = fetch_pc_q;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;

  // Requests since the last redirect are consecutive words, so the oldest
  // in-flight request sits outst_q words behind fetch_pc.
  assign rsp_pc  = fetch_pc_q - (32'(outst_q) << 2);
  assign rsp_hit = imem.imem_rsp_valid && (state_q == FETCH) && (outst_q != '0);
  assign push    = rsp_hit && !redirect;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && !stall;
  assign inst       = inst_valid ? word_mem_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        outst_d = outst_q + CNT_W'(accept) - CNT_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push)   wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end
      FLUSH: begin
        if (imem.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        state_d = (drop_d == '0) ? FETCH : FLUSH;
      end
      default: state_d = BOOT;
    endcase
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // While already flushing, the drop count keeps draining and is not reloaded.
      if (state_q != FLUSH) begin
        outst_d = '0;
        drop_d  = outst_q - CNT_W'(rsp_hit);
        state_d = (drop_d != '0) ? FLUSH : FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc;
      word_mem_q[wr_ptr_q] <= imem.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table, directed corner sequences and a random run,
// all checked against a queue-level model of the fetch stream and imem.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] MASK   = 32'hFFFF_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit_if ifc();

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (ifc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clock = ~clock;

  // kind: 0 = live request, 1 = stale after redirect, 2 = issued before a reset
  typedef struct {
    int unsigned due;
    logic [31:0] addr;
    int          kind;
  } ent_t;

  typedef struct {
    bit          stall;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  ent_t        mq[$];
  logic [31:0] mbuf[$];
  logic [31:0] exp_fetch;
  bit          boot_pending;
  int unsigned cyc;
  int unsigned last_due;
  int          checks;
  int          errors;
  int          lat;
  bit          rand_lat;
  bit          ready_req;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_inst;
  vec_t        vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock: drive imem inputs, sample at negedge, check and advance the model.
  task automatic tick();
    ent_t        cur;
    ent_t        ne;
    bit          have;
    bit          ghosts;
    bit          exp_rv;
    bit          exp_iv;
    bit          acc;
    int          live;
    int          stl;
    int          outst_reg;
    int          drop_reg;
    int unsigned l;
    int unsigned due;
    have = 1'b0;
    cur  = '{due: 0, addr: 32'h0, kind: 0};
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      cur  = mq.pop_front();
      have = 1'b1;
    end
    ghosts = 1'b0;
    foreach (mq[i]) if (mq[i].kind == 2) ghosts = 1'b1;
    ifc.imem_rsp_valid = have;
    ifc.imem_rsp_data  = have ? (cur.addr ^ MASK) : 32'hDEAD_BEEF;
    ifc.imem_req_ready = ready_req && !reset && !ghosts;
    @(negedge clock);
    s_rv   = ifc.imem_req_valid;
    s_addr = ifc.imem_req_addr;
    s_iv   = inst_valid;
    s_pc   = inst_pc;
    s_inst = inst;
    if (reset) begin
      foreach (mq[i]) mq[i].kind = 2;
      mbuf.delete();
      exp_fetch    = RST_PC;
      boot_pending = 1'b1;
    end else begin
      live = 0;
      stl  = 0;
      foreach (mq[i]) begin
        if (mq[i].kind == 0) live++;
        else if (mq[i].kind == 1) stl++;
      end
      outst_reg = live + ((have && cur.kind == 0) ? 1 : 0);
      drop_reg  = stl + ((have && cur.kind == 1) ? 1 : 0);
      exp_iv = (mbuf.size() > 0);
      chk("inst_valid", {31'b0, s_iv}, {31'b0, exp_iv});
      if (exp_iv && s_iv) begin
        chk("inst_pc", s_pc, mbuf[0]);
        chk("inst", s_inst, mbuf[0] ^ MASK);
      end
      if (boot_pending) begin
        chk("reset_inst", s_inst, 32'h0);
        chk("reset_inst_pc", s_pc, 32'h0);
      end
      exp_rv = !boot_pending && !redirect && (drop_reg == 0) &&
               (outst_reg + mbuf.size() < DEPTH);
      chk("req_valid", {31'b0, s_rv}, {31'b0, exp_rv});
      if (s_rv && exp_rv) chk("req_addr", s_addr, exp_fetch);
      acc = s_rv && ifc.imem_req_ready;
      if (redirect) begin
        foreach (mq[i]) if (mq[i].kind == 0) mq[i].kind = 1;
        mbuf.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_iv && !stall) void'(mbuf.pop_front());
        if (have && cur.kind == 0) mbuf.push_back(cur.addr);
      end
      if (acc) begin
        l   = rand_lat ? $urandom_range(4, 1) : lat;
        due = cyc + l;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ne.due  = due;
        ne.addr = s_addr;
        ne.kind = redirect ? 1 : 0;
        mq.push_back(ne);
        if (!redirect) exp_fetch = exp_fetch + 32'd4;
      end
      boot_pending = 1'b0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Let every in-flight response come back so a fresh reset starts from a quiet imem.
  task automatic drain();
    ready_req = 1'b0;
    redirect  = 1'b0;
    stall     = 1'b0;
    for (int k = 0; k < 20 && mq.size() > 0; k++) tick();
    ready_req = 1'b1;
  endtask

  task automatic watch_first_inst(input string name, input logic [31:0] want);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (s_iv) begin
        chk(name, s_pc, want);
        found = 1'b1;
      end
    end
    chk({name, "_seen"}, {31'b0, found}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; last_due = 0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    ready_req = 1'b1; lat = 1; rand_lat = 1'b0;
    exp_fetch = RST_PC; boot_pending = 1'b1;

    // Expected cycle-by-cycle behaviour after reset with a 1-cycle imem.
    vecs[0] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, RST_PC,      1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, RST_PC + 4,  1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,       1'b1, RST_PC};
    vecs[4] = '{1'b0, 1'b1, RST_PC + 8,  1'b1, RST_PC + 4};
    vecs[5] = '{1'b0, 1'b1, RST_PC + 12, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0,       1'b1, RST_PC + 8};
    vecs[7] = '{1'b0, 1'b1, RST_PC + 16, 1'b1, RST_PC + 12};
    vecs[8] = '{1'b0, 1'b1, RST_PC + 20, 1'b0, 32'h0};

    do_reset(2);
    for (int i = 0; i < 9; i++) begin
      stall = vecs[i].stall;
      tick();
      chk("tbl_req_valid", {31'b0, s_rv}, {31'b0, vecs[i].rv});
      if (vecs[i].rv) chk("tbl_req_addr", s_addr, vecs[i].addr);
      chk("tbl_inst_valid", {31'b0, s_iv}, {31'b0, vecs[i].iv});
      if (vecs[i].iv) begin
        chk("tbl_inst_pc", s_pc, vecs[i].pc);
        chk("tbl_inst", s_inst, vecs[i].pc ^ MASK);
      end
    end

    // Decode stalled from the start: buffer fills, requests stop, head holds.
    drain(); do_reset(1); lat = 1; stall = 1'b1;
    repeat (8) tick();
    chk("stall_iv", {31'b0, s_iv}, 32'h1);
    chk("stall_pc", s_pc, RST_PC);
    chk("stall_req_valid", {31'b0, s_rv}, 32'h0);
    stall = 1'b0;
    tick(); chk("unstall_pc0", s_pc, RST_PC);
    tick(); chk("unstall_iv1", {31'b0, s_iv}, 32'h1); chk("unstall_pc1", s_pc, RST_PC + 4);

    // imem not ready for 3 cycles: request held with a stable address.
    drain(); do_reset(1); lat = 1;
    tick(); tick();
    ready_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("nrdy_req_valid", {31'b0, s_rv}, 32'h1);
      chk("nrdy_req_addr", s_addr, RST_PC + 4);
    end
    ready_req = 1'b1;
    tick(); chk("rdy_addr0", s_addr, RST_PC + 4);
    tick(); chk("rdy_valid1", {31'b0, s_rv}, 32'h1); chk("rdy_addr1", s_addr, RST_PC + 8);

    // Redirect with two responses in flight on a 3-cycle imem.
    drain(); do_reset(1); lat = 3;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0100_0203;
    tick(); chk("flush_req_c3", {31'b0, s_rv}, 32'h0);
    redirect = 1'b0;
    tick(); chk("flush_req_c4", {31'b0, s_rv}, 32'h0);
    tick(); chk("flush_req_c5", {31'b0, s_rv}, 32'h0);
    tick(); chk("flush_req_c6", {31'b0, s_rv}, 32'h1); chk("flush_addr", s_addr, 32'h0100_0200);
    watch_first_inst("flush_first_pc", 32'h0100_0200);

    // Redirect coinciding with a response and a pop.
    drain(); do_reset(1); lat = 1;
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick(); chk("same_cyc_pop_iv", {31'b0, s_iv}, 32'h1);
    redirect = 1'b0;
    tick();
    chk("same_cyc_iv_next", {31'b0, s_iv}, 32'h0);
    chk("same_cyc_req", {31'b0, s_rv}, 32'h1);
    chk("same_cyc_addr", s_addr, 32'h0000_0040);

    // Back-to-back redirects while flushing: the later target wins.
    drain(); do_reset(1); lat = 3;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0040; tick();
    redirect_pc = 32'h0000_0080; tick();
    chk("b2b_req_c4", {31'b0, s_rv}, 32'h0);
    redirect = 1'b0;
    tick(); chk("b2b_req_c5", {31'b0, s_rv}, 32'h0);
    tick(); chk("b2b_req_c6", {31'b0, s_rv}, 32'h1); chk("b2b_addr", s_addr, 32'h0000_0080);

    // Fetch address wraps past the top of the address space.
    drain(); do_reset(1); lat = 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); chk("wrap_redir_req", {31'b0, s_rv}, 32'h0);
    redirect = 1'b0;
    tick(); chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    tick(); chk("wrap_addr_zero", s_addr, 32'h0000_0000);

    // Reset with two requests outstanding; their late responses must be ignored.
    drain(); do_reset(1); lat = 3;
    tick(); tick(); tick();
    do_reset(1);
    tick();
    chk("rst_mid_req", {31'b0, s_rv}, 32'h0);
    chk("rst_mid_iv", {31'b0, s_iv}, 32'h0);
    chk("rst_mid_inst", s_inst, 32'h0);
    chk("rst_mid_pc", s_pc, 32'h0);
    watch_first_inst("rst_mid_first_pc", RST_PC);

    // Random traffic against the model.
    drain(); do_reset(1); rand_lat = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(399, 0) == 0) begin
        do_reset(1);
        continue;
      end
      ready_req   = ($urandom_range(3, 0) != 0);
      stall       = ($urandom_range(2, 0) == 0);
      redirect    = ($urandom_range(24, 0) == 0);
      redirect_pc = $urandom();
      tick();
    end
    redirect = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
